// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between the CPU
// load/store path (port A) and a debug/loader port (port B).
// Every access is registered and walks IDLE -> ACCESS -> WAIT -> ACK.
// Arbitration is fixed CPU priority with a starvation guard for port B.
// Optional build macro ARB_ROUND_ROBIN_EN: when both ports are pending, the
// grant alternates away from the last winner and the starvation guard is
// removed.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int MEM_AW     = 8,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  // port A: CPU load/store path
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  // port B: debug/loader port
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  // status
  output logic              err,
  output logic              busy,
  output logic              gnt_b,
  // RAM side
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_ACK    = 2'd3
  } state_e;

  localparam int                SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [DATA_W-1:0] ZERO_DATA  = '0;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                gnt_b_q, gnt_b_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
`ifndef ARB_ROUND_ROBIN_EN
  logic [SW-1:0]       starve_q, starve_d;
`endif

  logic oor;     // latched address points at the I/O region, not the RAM
  logic take_b;  // port B wins if a grant is made this cycle

  assign oor = addr_q[ADDR_W-1];

  // Winner selection; only consulted while IDLE.
`ifdef ARB_ROUND_ROBIN_EN
  assign take_b = b_req && (!a_req || !gnt_b_q);
`else
  assign take_b = b_req && (!a_req || (starve_q == STARVE_LIM));
`endif

  // RAM address/data come straight from the latched request, so they stay
  // stable from ACCESS through WAIT while the synchronous read completes.
  assign mem_addr = addr_q[MEM_AW-1:0];
  assign mem_din  = wdata_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign gnt_b    = gnt_b_q;
  assign busy     = (state_q != S_IDLE);

  // Next-state, request latching, read capture and per-state strobes.
  always_comb begin
    // NOTE: every signal assigned below gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    gnt_b_d   = gnt_b_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifndef ARB_ROUND_ROBIN_EN
    starve_d  = starve_q;
`endif
    mem_write = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
`ifndef ARB_ROUND_ROBIN_EN
        if (!b_req) starve_d = '0;
`endif
        if (a_req || b_req) begin
          state_d = S_ACCESS;
          gnt_b_d = take_b;
          we_d    = take_b ? b_we    : a_we;
          addr_d  = take_b ? b_addr  : a_addr;
          wdata_d = take_b ? b_wdata : a_wdata;
`ifndef ARB_ROUND_ROBIN_EN
          if (take_b) begin
            starve_d = '0;
          end else if (b_req && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 1'b1;
          end
`endif
        end
      end

      S_ACCESS: begin
        // Single-cycle write strobe; I/O-region addresses never touch RAM.
        mem_write = we_q && !oor;
        state_d   = S_WAIT;
      end

      S_WAIT: begin
        // mem_dout now reflects the address presented during ACCESS.
        if (!we_q) begin
          if (gnt_b_q) b_rdata_d = oor ? ZERO_DATA : mem_dout;
          else         a_rdata_d = oor ? ZERO_DATA : mem_dout;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        a_ack   = !gnt_b_q;
        b_ack   = gnt_b_q;
        err     = oor;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      gnt_b_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifndef ARB_ROUND_ROBIN_EN
      starve_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of its inputs, independent of statement order.
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      gnt_b_q   <= gnt_b_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifndef ARB_ROUND_ROBIN_EN
      starve_q  <= starve_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural 256x16 synchronous RAM,
// a table of single-port accesses, and hand-written sequences for
// arbitration order and reset during an access.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [8:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack, err, busy, gnt_b, mem_write;
  logic [15:0] a_rdata, b_rdata, mem_din, mem_dout;
  logic [7:0]  mem_addr;

  // RAM model with a side load port for preloading
  logic [15:0] ram [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(9), .MEM_AW(8), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .err      (err),
    .busy     (busy),
    .gnt_b    (gnt_b),
    .mem_addr (mem_addr),
    .mem_write(mem_write),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  // Synchronous single-port RAM: read data one clock after the address.
  always @(posedge clk) begin
    if (ld_en)          ram[ld_addr]  <= ld_data;
    else if (mem_write) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One complete access on one port; reports what was seen on the way.
  task automatic do_access(input logic pb, input logic we, input logic [8:0] addr,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd,
                           output logic er, output int nwr, output logic [7:0] waddr,
                           output logic other, output logic bsy, output logic gb);
    @(negedge clk);
    if (pb) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd; end
    lat = -1; rd = '0; er = 1'b0; nwr = 0; waddr = '0; other = 1'b0; bsy = 1'b0; gb = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (mem_write) begin nwr++; waddr = mem_addr; end
      if (pb ? a_ack : b_ack) other = 1'b1;
      if (pb ? b_ack : a_ack) begin
        lat = n; rd = pb ? b_rdata : a_rdata; er = err; bsy = busy; gb = gnt_b;
        break;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  typedef struct {
    logic        port_b;
    logic        we;
    logic [8:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_writes;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, nwr, got;
    logic [15:0] rd;
    logic [7:0]  waddr;
    logic        er, other, bsy, gb, ack_seen;
    logic        exp_order [10];

    reset_n = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;

    // ---- reset state ----
    #1;
    check("rst_a_ack",     32'(a_ack),     0);
    check("rst_b_ack",     32'(b_ack),     0);
    check("rst_err",       32'(err),       0);
    check("rst_busy",      32'(busy),      0);
    check("rst_gnt_b",     32'(gnt_b),     0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_a_rdata",   32'(a_rdata),   0);
    check("rst_b_rdata",   32'(b_rdata),   0);
    check("rst_mem_addr",  32'(mem_addr),  0);
    check("rst_mem_din",   32'(mem_din),   0);

    load(8'h05, 16'hD401);
    load(8'h00, 16'h1234);
    load(8'h14, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // {port_b, we, addr, wdata, exp_rdata, exp_err, exp_writes}
    vecs[0] = '{1'b0, 1'b0, 9'h005, 16'h0000, 16'hD401, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 9'h014, 16'h0352, 16'h0000, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b0, 9'h014, 16'h0000, 16'd850,  1'b0, 0};
    vecs[3] = '{1'b0, 1'b1, 9'h100, 16'hFFFF, 16'd850,  1'b1, 0};
    vecs[4] = '{1'b1, 1'b0, 9'h005, 16'h0000, 16'hD401, 1'b0, 0};
    vecs[5] = '{1'b1, 1'b0, 9'h1FF, 16'h0000, 16'h0000, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b1, 9'h0FF, 16'hA5A5, 16'd850,  1'b0, 1};
    vecs[7] = '{1'b0, 1'b0, 9'h0FF, 16'h0000, 16'hA5A5, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b0, 9'h014, 16'h0000, 16'h0352, 1'b0, 0};

    for (int i = 0; i < 9; i++) begin
      do_access(vecs[i].port_b, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                lat, rd, er, nwr, waddr, other, bsy, gb);
      check($sformatf("v%0d_latency", i), 32'(lat), 3);
      check($sformatf("v%0d_rdata", i),   32'(rd),  32'(vecs[i].exp_rdata));
      check($sformatf("v%0d_err", i),     32'(er),  32'(vecs[i].exp_err));
      check($sformatf("v%0d_writes", i),  32'(nwr), 32'(vecs[i].exp_writes));
      if (vecs[i].exp_writes == 1)
        check($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vecs[i].addr[7:0]));
      check($sformatf("v%0d_other_ack", i), 32'(other), 0);
      check($sformatf("v%0d_busy", i),      32'(bsy),   1);
      check($sformatf("v%0d_gnt_b", i),     32'(gb),    32'(vecs[i].port_b));
    end
    check("ram00_unchanged", 32'(ram[8'h00]), 32'h1234);
    check("ram14_written",   32'(ram[8'h14]), 32'h0352);
    check("ramff_written",   32'(ram[8'hFF]), 32'hA5A5);

    // ---- both requesters held continuously ----
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 10; i++) exp_order[i] = (i % 2) != 0;  // last winner was B
`else
    for (int i = 0; i < 10; i++) exp_order[i] = (i == 4) || (i == 9);
`endif
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 9'h005;
    b_req = 1'b1; b_we = 1'b0; b_addr = 9'h014;
    got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        check($sformatf("grant%0d_owner", got), 32'(b_ack), 32'(exp_order[got]));
        if (b_ack) check($sformatf("grant%0d_b_rdata", got), 32'(b_rdata), 32'h0352);
        else       check($sformatf("grant%0d_a_rdata", got), 32'(a_rdata), 32'hD401);
        got++;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("grant_count", 32'(got), 10);

    // ---- reset during ACCESS of a port-B write ----
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 9'h033; b_wdata = 16'hBEEF;
    @(negedge clk);
    check("abort_write_in_access", 32'(mem_write), 1);
    #1 reset_n = 1'b0;
    #1;
    check("abort_mem_write_drop", 32'(mem_write), 0);
    check("abort_busy_drop",      32'(busy),      0);
    b_req = 1'b0;
    ack_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b_ack || a_ack) ack_seen = 1'b1;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (b_ack || a_ack) ack_seen = 1'b1;
    end
    check("abort_no_ack",     32'(ack_seen), 0);
    check("abort_busy_after", 32'(busy),     0);
    do_access(1'b1, 1'b0, 9'h005, 16'h0000, lat, rd, er, nwr, waddr, other, bsy, gb);
    check("post_abort_latency", 32'(lat), 3);
    check("post_abort_rdata",   32'(rd),  32'hD401);
    check("post_abort_err",     32'(er),  0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
